// File: rtl/switch_pkg.sv
// Shared types and helpers for the switch jump-table loader.
package switch_pkg;

    typedef enum logic [1:0] {
        ACCEPT = 2'd0,
        UNPACK = 2'd1,
        DONE   = 2'd2
    } loader_state_t;

    function automatic int lanes(input int in_w, input int adr_w);
        return in_w / adr_w;
    endfunction

endpackage

// File: rtl/switch_table_loader.sv
// Unpacks wide input beats into one table entry per clock for the switch jump-table
// write port, counting entries up to the table depth and flagging completion/overflow.
module switch_table_loader
    import switch_pkg::*;
#(
    parameter int ADR_BUS_WIDTH    = 8,
    parameter int IN_WIDTH         = 32,
    parameter int SWITCH_MEM_WORDS = 256,
    localparam int LANES           = lanes(IN_WIDTH, ADR_BUS_WIDTH),
    localparam int CW              = $clog2(SWITCH_MEM_WORDS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [IN_WIDTH-1:0]      s_tdata,
    input  logic                     s_tvalid,
    input  logic                     s_tlast,
    output logic                     s_tready,
    output logic [ADR_BUS_WIDTH-1:0] switch_tdata,
    output logic                     switch_tvalid,
    output logic [CW-1:0]            word_count,
    output logic                     load_done,
    output logic                     load_overflow
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);
    localparam logic [CW-1:0] COUNT_LAST = CW'(SWITCH_MEM_WORDS - 1);
    localparam logic [CW-1:0] COUNT_MAX  = CW'(SWITCH_MEM_WORDS);

    if (((IN_WIDTH % ADR_BUS_WIDTH) != 0) || (LANES < 1)) begin : g_param_chk
        $error("switch_table_loader: IN_WIDTH must be a non-zero multiple of ADR_BUS_WIDTH");
    end

    loader_state_t              state_r, state_nxt_s;
    logic [IN_WIDTH-1:0]        hold_r, hold_nxt_s;
    logic                       hold_last_r, hold_last_nxt_s;
    logic [LW-1:0]              lane_r, lane_nxt_s;
    logic [ADR_BUS_WIDTH-1:0]   tdata_nxt_s, lane_data_s;
    logic                       tvalid_nxt_s;
    logic [CW-1:0]              count_nxt_s;
    logic                       done_nxt_s, ovf_nxt_s;
    logic                       beat_s, lane_is_last_s;

    assign lane_is_last_s = (lane_r == LANE_LAST);
    assign lane_data_s    = hold_r[ADR_BUS_WIDTH*int'(lane_r) +: ADR_BUS_WIDTH];
    // Ready only when no lanes of a held beat remain pending after this cycle
    assign s_tready       = (state_r != UNPACK) || lane_is_last_s;
    assign beat_s         = s_tvalid && s_tready;

    // Next-state, lane sequencing, counters and flags
    always_comb begin
        state_nxt_s     = state_r;
        hold_nxt_s      = hold_r;
        hold_last_nxt_s = hold_last_r;
        lane_nxt_s      = lane_r;
        tdata_nxt_s     = {ADR_BUS_WIDTH{1'b0}};
        tvalid_nxt_s    = 1'b0;
        count_nxt_s     = word_count;
        done_nxt_s      = load_done;
        ovf_nxt_s       = load_overflow;
        if (start) begin
            state_nxt_s     = ACCEPT;
            hold_nxt_s      = {IN_WIDTH{1'b0}};
            hold_last_nxt_s = 1'b0;
            lane_nxt_s      = {LW{1'b0}};
            count_nxt_s     = {CW{1'b0}};
            done_nxt_s      = 1'b0;
            ovf_nxt_s       = 1'b0;
        end else begin
            case (state_r)
                ACCEPT: begin
                    if (beat_s) begin
                        hold_nxt_s      = s_tdata;
                        hold_last_nxt_s = s_tlast;
                        lane_nxt_s      = {LW{1'b0}};
                        state_nxt_s     = UNPACK;
                    end else begin
                        state_nxt_s     = ACCEPT;
                    end
                end
                UNPACK: begin
                    tvalid_nxt_s = 1'b1;
                    tdata_nxt_s  = lane_data_s;
                    if (word_count < COUNT_MAX) begin
                        count_nxt_s = word_count + {{(CW-1){1'b0}}, 1'b1};
                    end else begin
                        count_nxt_s = word_count;
                    end
                    if (word_count == COUNT_LAST) begin
                        // Table full: anything not yet emitted or not closed by tlast is lost
                        state_nxt_s = DONE;
                        done_nxt_s  = 1'b1;
                        if (!lane_is_last_s || !hold_last_r || beat_s) begin
                            ovf_nxt_s = 1'b1;
                        end else begin
                            ovf_nxt_s = load_overflow;
                        end
                    end else if (lane_is_last_s) begin
                        if (hold_last_r) begin
                            state_nxt_s = DONE;
                            done_nxt_s  = 1'b1;
                            if (beat_s) begin
                                ovf_nxt_s = 1'b1;
                            end else begin
                                ovf_nxt_s = load_overflow;
                            end
                        end else if (beat_s) begin
                            hold_nxt_s      = s_tdata;
                            hold_last_nxt_s = s_tlast;
                            lane_nxt_s      = {LW{1'b0}};
                        end else begin
                            state_nxt_s     = ACCEPT;
                        end
                    end else begin
                        lane_nxt_s = lane_r + {{(LW-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    if (beat_s) begin
                        ovf_nxt_s = 1'b1;
                    end else begin
                        ovf_nxt_s = load_overflow;
                    end
                end
                default: begin
                    state_nxt_s = ACCEPT;
                end
            endcase
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ACCEPT;
            hold_r        <= {IN_WIDTH{1'b0}};
            hold_last_r   <= 1'b0;
            lane_r        <= {LW{1'b0}};
            switch_tdata  <= {ADR_BUS_WIDTH{1'b0}};
            switch_tvalid <= 1'b0;
            word_count    <= {CW{1'b0}};
            load_done     <= 1'b0;
            load_overflow <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            hold_r        <= hold_nxt_s;
            hold_last_r   <= hold_last_nxt_s;
            lane_r        <= lane_nxt_s;
            switch_tdata  <= tdata_nxt_s;
            switch_tvalid <= tvalid_nxt_s;
            word_count    <= count_nxt_s;
            load_done     <= done_nxt_s;
            load_overflow <= ovf_nxt_s;
        end
    end

endmodule

// File: tb/tb_switch_table_loader.sv
// Scoreboard bench for switch_table_loader with a 16-entry table.
module tb_switch_table_loader;

    localparam int AW = 8;
    localparam int IW = 32;
    localparam int W  = 16;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [IW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [AW-1:0] switch_tdata;
    logic          switch_tvalid;
    logic [CW-1:0] word_count;
    logic          load_done;
    logic          load_overflow;

    int err_cnt = 0;
    int chk_cnt = 0;
    int cyc = 0;
    int n_seen = 0;
    int first_cyc = 0;
    int last_cyc = 0;
    logic [AW-1:0] exp_q[$];
    int  m_cnt = 0;
    bit  m_done = 1'b0;
    bit  m_ovf = 1'b0;

    switch_table_loader #(
        .ADR_BUS_WIDTH(AW),
        .IN_WIDTH(IW),
        .SWITCH_MEM_WORDS(W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .s_tdata(s_tdata),
        .s_tvalid(s_tvalid),
        .s_tlast(s_tlast),
        .s_tready(s_tready),
        .switch_tdata(switch_tdata),
        .switch_tvalid(switch_tvalid),
        .word_count(word_count),
        .load_done(load_done),
        .load_overflow(load_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    // Output monitor: every emitted entry must match the head of the scoreboard
    always @(negedge clk) begin
        logic [AW-1:0] e;
        if (!rst && switch_tvalid) begin
            n_seen++;
            if (n_seen == 1) first_cyc = cyc;
            last_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_entry", 32'(switch_tdata), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check_eq("entry", 32'(switch_tdata), 32'(e));
            end
        end
    end

    task automatic model_clear();
        exp_q.delete();
        m_cnt = 0; m_done = 1'b0; m_ovf = 1'b0;
        n_seen = 0;
    endtask

    task automatic model_beat(input logic [IW-1:0] d, input logic l);
        if (m_done) begin
            m_ovf = 1'b1;
        end else begin
            for (int i = 0; i < IW/AW; i++) begin
                if (!m_done) begin
                    exp_q.push_back(d[i*AW +: AW]);
                    m_cnt++;
                    if (m_cnt == W) begin
                        m_done = 1'b1;
                        if (i != IW/AW - 1 || !l) m_ovf = 1'b1;
                    end
                end
            end
            if (l) m_done = 1'b1;
        end
    endtask

    task automatic send_beat(input logic [IW-1:0] d, input logic l);
        int guard = 0;
        s_tdata = d; s_tvalid = 1'b1; s_tlast = l;
        while (!s_tready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq("tready_timeout", 32'(guard < 50), 32'd1);
        model_beat(d, l);
        @(posedge clk); #1;
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic wait_empty();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        check_eq("drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_flags(input string tag);
        check_eq({tag, "_count"}, 32'(word_count), 32'(m_cnt));
        check_eq({tag, "_done"}, 32'(load_done), 32'(m_done));
        check_eq({tag, "_ovf"}, 32'(load_overflow), 32'(m_ovf));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        model_clear();
    endtask

    initial begin
        // Reset values
        #12;
        check_eq("rst_tready", 32'(s_tready), 32'd1);
        check_eq("rst_tvalid", 32'(switch_tvalid), 32'd0);
        check_eq("rst_tdata", 32'(switch_tdata), 32'd0);
        check_eq("rst_count", 32'(word_count), 32'd0);
        check_eq("rst_done", 32'(load_done), 32'd0);
        check_eq("rst_ovf", 32'(load_overflow), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Streaming, exact fill with tlast on the final beat
        model_clear();
        for (int b = 0; b < 4; b++) begin
            logic [IW-1:0] d;
            for (int k = 0; k < 4; k++) d[k*8 +: 8] = 8'(b*4 + k);
            send_beat(d, b == 3);
        end
        wait_empty();
        check_flags("stream");
        check_eq("stream_seen", 32'(n_seen), 32'd16);
        check_eq("stream_contig", 32'(last_cyc - first_cyc), 32'd15);
        pulse_start();
        check_flags("start_clear");

        // Table fill: 5 beats without tlast, only W entries get through
        for (int b = 0; b < 5; b++) send_beat(32'hA0A1A2A3 + 32'(b * 32'h04040404), 1'b0);
        wait_empty();
        check_flags("fill");
        check_eq("fill_seen", 32'(n_seen), 32'd16);
        check_eq("fill_tvalid_low", 32'(switch_tvalid), 32'd0);
        pulse_start();

        // Gapped input, short image
        send_beat(32'h13121110, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        send_beat(32'h17161514, 1'b1);
        wait_empty();
        check_flags("gap");
        check_eq("gap_seen", 32'(n_seen), 32'd8);

        // Drain: beat in DONE is swallowed and flagged
        send_beat(32'hDEADBEEF, 1'b0);
        wait_empty();
        check_flags("drain");
        check_eq("drain_seen", 32'(n_seen), 32'd8);
        pulse_start();
        check_flags("drain_start");

        // start coincident with a handshake drops the beat
        s_tdata = 32'h55667788; s_tvalid = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        s_tvalid = 1'b0; start = 1'b0;
        model_clear();
        repeat (8) @(posedge clk);
        #1;
        check_eq("start_drop_seen", 32'(n_seen), 32'd0);
        check_flags("start_drop");

        // Asynchronous reset in the middle of unpacking
        send_beat(32'h44332211, 1'b0);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check_eq("arst_tvalid", 32'(switch_tvalid), 32'd0);
        check_eq("arst_count", 32'(word_count), 32'd0);
        model_clear();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("arst_tready", 32'(s_tready), 32'd1);
        check_flags("arst");
        repeat (4) @(posedge clk);
        #1;
        check_eq("arst_seen", 32'(n_seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
